// File: rtl/perf_counter_unit.sv
// perf_counter_unit: saturating pipeline event counters plus an iterative
// restoring divider that periodically publishes cycles-per-instruction.
// Optional feature macro: PERF_OVERFLOW_FLAG_EN adds sticky ovf_flags[4:0]
// (bit0 stall, bit1 arith, bit2 mem, bit3 instr, bit4 cycle).
module perf_counter_unit #(
   parameter int unsigned CNT_WIDTH = 19
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 freeze,
   input  logic                 clear,
   input  logic                 stall,
   input  logic                 retire_valid,
   input  logic                 retire_is_arith,
   input  logic                 retire_is_mem,
   output logic [CNT_WIDTH-1:0] stall_count,
   output logic [CNT_WIDTH-1:0] aritmetric_count,
   output logic [CNT_WIDTH-1:0] memory_count,
   output logic [CNT_WIDTH-1:0] instruction_count,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic [CNT_WIDTH-1:0] cpi,
   output logic                 cpi_valid
`ifdef PERF_OVERFLOW_FLAG_EN
   ,
   output logic [4:0]           ovf_flags
`endif
);

   localparam int unsigned NUM_CNT = 5;
   localparam int unsigned STEP_W  = $clog2(CNT_WIDTH + 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE,
      DIV,
      DONE
   } state_t;

   // Counter index map: 0 stall, 1 arith, 2 mem, 3 instr, 4 cycle
   logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
   logic [NUM_CNT-1:0]   inc;

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] dq_q, dq_d;     // dividend shifts out MSB, quotient shifts in LSB
   logic [CNT_WIDTH-1:0] dvs_q, dvs_d;
   logic [CNT_WIDTH-1:0] rem_q, rem_d;
   logic [STEP_W-1:0]    step_q, step_d;
   logic [CNT_WIDTH-1:0] cpi_d;
   logic                 cpi_valid_d;
   logic [CNT_WIDTH:0]   rem_sh;
   logic [CNT_WIDTH-1:0] rem_sub;

   assign inc = {1'b1,
                 retire_valid,
                 retire_valid & retire_is_mem,
                 retire_valid & retire_is_arith,
                 stall};

   assign stall_count       = cnt_q[0];
   assign aritmetric_count  = cnt_q[1];
   assign memory_count      = cnt_q[2];
   assign instruction_count = cnt_q[3];
   assign cycle_count       = cnt_q[4];

   assign rem_sh  = {rem_q, dq_q[CNT_WIDTH-1]};
   assign rem_sub = CNT_WIDTH'(rem_sh - {1'b0, dvs_q});

   // Event counters: saturate at all-ones, hold while frozen
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         for (int i = 0; i < NUM_CNT; i++) cnt_q[i] <= '0;
      end else if (!freeze) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            if (inc[i] && (cnt_q[i] != CNT_MAX)) cnt_q[i] <= cnt_q[i] + CNT_WIDTH'(1);
         end
      end
   end

`ifdef PERF_OVERFLOW_FLAG_EN
   // Sticky flag per counter: increment attempted while already saturated
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         ovf_flags <= '0;
      end else if (!freeze) begin
         for (int i = 0; i < NUM_CNT; i++) begin
            if (inc[i] && (cnt_q[i] == CNT_MAX)) ovf_flags[i] <= 1'b1;
         end
      end
   end
`endif

   // Divider FSM state and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         dq_q      <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         step_q    <= '0;
         cpi       <= '0;
         cpi_valid <= 1'b0;
      end else begin
         state_q   <= state_d;
         dq_q      <= dq_d;
         dvs_q     <= dvs_d;
         rem_q     <= rem_d;
         step_q    <= step_d;
         cpi       <= cpi_d;
         cpi_valid <= cpi_valid_d;
      end
   end

   // Divider next-state: snapshot, one restoring step per cycle, publish
   always_comb begin
      state_d     = state_q;
      dq_d        = dq_q;
      dvs_d       = dvs_q;
      rem_d       = rem_q;
      step_d      = step_q;
      cpi_d       = cpi;
      cpi_valid_d = 1'b0;
      if (clear) begin
         state_d = IDLE;
      end else if (!freeze) begin
         case (state_q)
            IDLE: begin
               if (cnt_q[3] != '0) begin
                  dq_d    = cnt_q[4];
                  dvs_d   = cnt_q[3];
                  rem_d   = '0;
                  step_d  = '0;
                  state_d = DIV;
               end
            end
            DIV: begin
               if (rem_sh >= {1'b0, dvs_q}) begin
                  rem_d = rem_sub;
                  dq_d  = {dq_q[CNT_WIDTH-2:0], 1'b1};
               end else begin
                  rem_d = rem_sh[CNT_WIDTH-1:0];
                  dq_d  = {dq_q[CNT_WIDTH-2:0], 1'b0};
               end
               step_d = step_q + STEP_W'(1);
               if (step_q == STEP_W'(CNT_WIDTH - 1)) state_d = DONE;
            end
            DONE: begin
               cpi_d       = dq_q;
               cpi_valid_d = 1'b1;
               state_d     = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule
